// File: rtl/picoramsoc_pkg.sv
// Shared types for the PicoRAM SoC memory arbiter: FSM states and grant encoding.
package picoramsoc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        GNT_D = 1'b0,
        GNT_I = 1'b1
    } gnt_t;

    // Bit positions of each requester in the req/gnt vectors
    localparam int unsigned REQ_D = 0;
    localparam int unsigned REQ_I = 1;

endpackage

// File: rtl/picoramsoc_rr_arb2.sv
// Two-way round-robin choice: a lone request always wins, a tie goes to the
// requester that was not granted last.
module picoramsoc_rr_arb2
    import picoramsoc_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_t       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == GNT_I) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/picoramsoc_mem_arbiter.sv
// Arbitrates a data port and an instruction port onto one synchronous
// single-port RAM: grant and RAM access in IDLE, acknowledge in WAIT.
module picoramsoc_mem_arbiter
    import picoramsoc_pkg::*;
#(
    parameter int WORDS  = 4096,
    parameter int ADDR_W = 22
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              d_valid,
    output logic              d_ready,
    input  logic [3:0]        d_wstrb,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,

    input  logic              i_valid,
    output logic              i_ready,
    input  logic [31:0]       i_addr,
    output logic [31:0]       i_rdata,

    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [32:0] LIMIT = 33'(WORDS) * 33'd4;

    state_t      r_state;
    gnt_t        r_gnt;
    gnt_t        r_last;
    logic        r_oor;

    logic [1:0]  w_gnt;
    logic        w_take;
    logic [31:0] w_addr;
    logic        w_in_range;

    picoramsoc_rr_arb2 u_rr (
        .req  ({i_valid, d_valid}),
        .last (r_last),
        .gnt  (w_gnt)
    );

    // RAM is driven straight from the winning request while in IDLE
    assign w_take     = resetn && (r_state == ST_IDLE) && (w_gnt != 2'b00);
    assign w_addr     = w_gnt[REQ_I] ? i_addr : d_addr;
    assign w_in_range = {1'b0, w_addr} < LIMIT;

    assign ram_en    = w_take && w_in_range;
    assign ram_wen   = (ram_en && w_gnt[REQ_D]) ? d_wstrb : '0;
    assign ram_addr  = w_addr[ADDR_W+1:2];
    assign ram_wdata = d_wdata;

    assign d_ready = (r_state == ST_WAIT) && (r_gnt == GNT_D);
    assign i_ready = (r_state == ST_WAIT) && (r_gnt == GNT_I);
    assign d_rdata = (d_ready && !r_oor) ? ram_rdata : '0;
    assign i_rdata = (i_ready && !r_oor) ? ram_rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_gnt   <= GNT_D;
            r_last  <= GNT_I;
            r_oor   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_state <= ST_WAIT;
                        r_gnt   <= w_gnt[REQ_I] ? GNT_I : GNT_D;
                        r_last  <= w_gnt[REQ_I] ? GNT_I : GNT_D;
                        r_oor   <= !w_in_range;
                    end
                end
                ST_WAIT: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picoramsoc_mem_arbiter.sv
// Bench for picoramsoc_mem_arbiter: RAM stub, transaction-level model with an
// every-cycle compare, and directed scenarios with literal expectations.
module tb_picoramsoc_mem_arbiter;

    localparam int WORDS  = 4096;
    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              d_valid = 1'b0;
    logic              d_ready;
    logic [3:0]        d_wstrb = 4'h0;
    logic [31:0]       d_addr = 32'h0;
    logic [31:0]       d_wdata = 32'h0;
    logic [31:0]       d_rdata;
    logic              i_valid = 1'b0;
    logic              i_ready;
    logic [31:0]       i_addr = 32'h0;
    logic [31:0]       i_rdata;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata = 32'h0;

    always #5 clk = ~clk;

    picoramsoc_mem_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_wstrb   (d_wstrb),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input int unsigned k);
        return 32'hC000_0000 | k;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // RAM stub: synchronous, read-before-write
    logic [31:0] s_mem [int unsigned];
    always @(posedge clk) begin : stub
        int unsigned k;
        logic [31:0] old;
        if (ram_en) begin
            k   = 32'(ram_addr);
            old = s_mem.exists(k) ? s_mem[k] : init_word(k);
            ram_rdata <= old;
            if (ram_wen != 4'h0) s_mem[k] = merge(old, ram_wdata, ram_wen);
        end
    end

    // Transaction model: one pending acknowledge, round-robin winner, word memory
    int          m_pend = 0;          // 0 none, 1 data, 2 instr
    logic        m_last_i = 1'b1;
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_mem [int unsigned];

    function automatic int m_winner();
        if (d_valid && i_valid) return m_last_i ? 1 : 2;
        if (d_valid) return 1;
        if (i_valid) return 2;
        return 0;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return {32'h0, a} < (64'(WORDS) * 64'd4);
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        int w;
        int unsigned k;
        logic [31:0] a, old;
        if (!resetn) begin
            m_pend   <= 0;
            m_last_i <= 1'b1;
            m_rdata  <= 32'h0;
        end else if (m_pend != 0) begin
            m_pend <= 0;
        end else begin
            w = m_winner();
            if (w != 0) begin
                a = (w == 1) ? d_addr : i_addr;
                m_pend   <= w;
                m_last_i <= (w == 2);
                if (in_range(a)) begin
                    k   = a / 4;
                    old = m_mem.exists(k) ? m_mem[k] : init_word(k);
                    m_rdata <= old;
                    if (w == 1 && d_wstrb != 4'h0) m_mem[k] = merge(old, d_wdata, d_wstrb);
                end else begin
                    m_rdata <= 32'h0;
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int w;
        logic [31:0] a;
        logic e_en, e_dr, e_ir;
        logic [3:0] e_wen;
        logic [31:0] e_drd, e_ird, e_addr;
        e_en = 0; e_wen = 0; e_dr = 0; e_ir = 0; e_drd = 0; e_ird = 0; e_addr = 0;
        if (resetn) begin
            if (m_pend == 1) begin
                e_dr = 1; e_drd = m_rdata;
            end else if (m_pend == 2) begin
                e_ir = 1; e_ird = m_rdata;
            end else begin
                w = m_winner();
                if (w != 0) begin
                    a = (w == 1) ? d_addr : i_addr;
                    if (in_range(a)) begin
                        e_en   = 1;
                        e_wen  = (w == 1) ? d_wstrb : 4'h0;
                        e_addr = a / 4;
                    end
                end
            end
        end
        chk("m_ram_en",  32'(ram_en),  32'(e_en));
        chk("m_ram_wen", 32'(ram_wen), 32'(e_wen));
        chk("m_d_ready", 32'(d_ready), 32'(e_dr));
        chk("m_i_ready", 32'(i_ready), 32'(e_ir));
        chk("m_d_rdata", d_rdata, e_drd);
        chk("m_i_rdata", i_rdata, e_ird);
        if (e_en) chk("m_ram_addr", 32'(ram_addr), e_addr);
        if (e_wen != 4'h0) chk("m_ram_wdata", ram_wdata, d_wdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int grants[$];

    initial begin
        // Reset with a request pending: RAM must stay idle
        tick();
        d_valid = 1'b1; d_addr = 32'h10;
        smp();
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_ram_en",  32'(ram_en),  32'd0);
        chk("rst_ram_wen", 32'(ram_wen), 32'd0);
        tick();
        d_valid = 1'b0; resetn = 1'b1;
        tick();

        // Tie after reset: data first, then instruction
        d_valid = 1'b1; d_wstrb = 4'h0; d_addr = 32'h20;
        i_valid = 1'b1; i_addr = 32'h100;
        smp();
        chk("tie_d_en",   32'(ram_en),   32'd1);
        chk("tie_d_addr", 32'(ram_addr), 32'h8);
        tick(); smp();
        chk("tie_d_ready", 32'(d_ready), 32'd1);
        chk("tie_d_rdata", d_rdata, 32'hC000_0008);
        chk("tie_i_wait",  32'(i_ready), 32'd0);
        tick();
        d_valid = 1'b0;
        smp();
        chk("tie_i_en",   32'(ram_en),   32'd1);
        chk("tie_i_addr", 32'(ram_addr), 32'h40);
        tick(); smp();
        chk("tie_i_ready", 32'(i_ready), 32'd1);
        chk("tie_i_rdata", i_rdata, 32'hC000_0040);
        tick();
        i_valid = 1'b0;
        tick();

        // Full-word write to 0x10
        d_valid = 1'b1; d_wstrb = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        smp();
        chk("wr_en",    32'(ram_en),   32'd1);
        chk("wr_wen",   32'(ram_wen),  32'hF);
        chk("wr_addr",  32'(ram_addr), 32'h4);
        chk("wr_wdata", ram_wdata,     32'hDEAD_BEEF);
        tick(); smp();
        chk("wr_ready", 32'(d_ready), 32'd1);
        chk("wr_wait_en", 32'(ram_en), 32'd0);
        tick();
        // Partial write, low half
        d_wstrb = 4'h3; d_wdata = 32'h1234_5678;
        tick(); tick();
        // Read back
        d_wstrb = 4'h0;
        tick(); smp();
        chk("rb_rdata", d_rdata, 32'hDEAD_5678);
        tick();
        // Last in-range word, then first out-of-range word
        d_wstrb = 4'hF; d_addr = 32'h3FFC; d_wdata = 32'h0BAD_F00D;
        smp();
        chk("edge_en",   32'(ram_en),   32'd1);
        chk("edge_addr", 32'(ram_addr), 32'hFFF);
        tick(); tick();
        d_addr = 32'h4000;
        smp();
        chk("oor_d_en",  32'(ram_en),  32'd0);
        chk("oor_d_wen", 32'(ram_wen), 32'd0);
        tick(); smp();
        chk("oor_d_ready", 32'(d_ready), 32'd1);
        chk("oor_d_rdata", d_rdata, 32'h0);
        tick();
        d_valid = 1'b0; d_wstrb = 4'h0;

        // Out-of-range instruction fetch, valid dropped right after grant
        i_valid = 1'b1; i_addr = 32'h4000;
        smp();
        chk("oor_i_en", 32'(ram_en), 32'd0);
        tick();
        i_valid = 1'b0;
        smp();
        chk("oor_i_ready", 32'(i_ready), 32'd1);
        chk("oor_i_rdata", i_rdata, 32'h0);
        tick();

        // Continuous contention: strict alternation starting with data
        d_valid = 1'b1; d_addr = 32'h200; i_valid = 1'b1; i_addr = 32'h300;
        for (int c = 0; c < 16; c++) begin
            smp();
            if (ram_en) grants.push_back((32'(ram_addr) == 32'h80) ? 0 : 1);
            chk("rr_overlap", 32'(d_ready & i_ready), 32'd0);
            tick();
        end
        d_valid = 1'b0; i_valid = 1'b0;
        chk("rr_count", 32'(grants.size()), 32'd8);
        for (int g = 0; g < grants.size(); g++) chk("rr_order", 32'(grants[g]), 32'(g % 2));
        tick();

        // Reset during WAIT abandons the access and restores data priority
        d_valid = 1'b1; d_addr = 32'h20;
        smp();
        chk("ab_en", 32'(ram_en), 32'd1);
        tick();
        resetn = 1'b0; d_valid = 1'b0;
        smp();
        chk("ab_d_ready", 32'(d_ready), 32'd0);
        tick(); tick();
        resetn = 1'b1;
        smp();
        chk("ab_post_ready", 32'(d_ready), 32'd0);
        tick();
        d_valid = 1'b1; d_addr = 32'h200; i_valid = 1'b1; i_addr = 32'h300;
        smp();
        chk("ab_tie_addr", 32'(ram_addr), 32'h80);
        tick(); smp();
        chk("ab_tie_ready", 32'(d_ready), 32'd1);
        tick();
        d_valid = 1'b0;
        smp();
        chk("ab_i_addr", 32'(ram_addr), 32'hC0);
        tick(); smp();
        chk("ab_i_ready", 32'(i_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/picoramsoc_mem_arbiter.md
PICORAMSOC_MEM_ARBITER -- requirements
Module: picoramsoc_mem_arbiter

Interface
REQ-001 SHALL have parameter WORDS, default 4096, meaning RAM depth in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 22, meaning RAM word-address width.
REQ-003 SHALL have port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have ports d_valid, d_ready, d_wstrb, d_addr, d_wdata, d_rdata: in 1, out 1, in 4, in 32, in 32, out 32. Data requester; byte address; wstrb==0 means read.
REQ-006 SHALL have ports i_valid, i_ready, i_addr, i_rdata: in 1, out 1, in 32, out 32. Instruction requester, read-only.
REQ-007 SHALL have ports ram_en, ram_wen, ram_addr, ram_wdata, ram_rdata: out 1, out 4, out ADDR_W, out 32, in 32. Single-port synchronous RAM; read data valid the cycle after ram_en.

Function
REQ-008 SHALL implement FSM states IDLE, WAIT; reset state IDLE.
REQ-009 In IDLE with at least one valid, SHALL grant exactly one requester, drive the RAM combinationally in that cycle, latch the grant, and go to WAIT.
REQ-010 On grant, ram_addr SHALL equal the winner's addr[ADDR_W+1:2], ram_wen = d_wstrb for data and 0 for instr, ram_wdata = d_wdata.
REQ-011 In WAIT, SHALL pulse the granted ready for exactly one cycle, present ram_rdata on that requester's rdata, then return to IDLE; ram_en SHALL be 0 in WAIT.
REQ-012 Latency SHALL be valid-to-ready = 1 cycle when uncontended; peak throughput 1 access per 2 cycles.
REQ-013 Tie-break SHALL be round-robin: on simultaneous d_valid and i_valid, grant the requester not granted last; last_grant updates only on a grant.
REQ-014 A lone valid requester SHALL always win regardless of last_grant.
REQ-015 A granted address >= 4*WORDS SHALL be out of range: ram_en and ram_wen held 0; still acknowledged in WAIT with rdata 0.
REQ-016 Non-granted ready SHALL be 0; rdata of a non-ready port SHALL be 0.
REQ-017 A requester SHALL hold valid and its request fields stable until ready; the arbiter SHALL NOT sample valid in WAIT.
REQ-018 A valid dropped by the requester after grant SHALL NOT cancel the WAIT-state acknowledge.

Reset
REQ-019 While resetn=0: state IDLE, last_grant = instr (data wins first tie), d_ready=i_ready=0, ram_en=0, ram_wen=0.
REQ-020 Reset asserted in WAIT SHALL abandon the access; no ready pulse after release.
REQ-021 The first grant SHALL occur no earlier than the first rising clk edge after resetn deasserts.

Structure
REQ-022 SHALL place the state enum and the grant encoding (GNT_D, GNT_I) in shared package picoramsoc_pkg.
REQ-023 SHALL factor the two-way round-robin choice into sub-module picoramsoc_rr_arb2: inputs req[1:0] and last; output gnt[1:0], one-hot or zero.
REQ-024 SHALL contain no memory array; RAM storage stays in the existing memory module.

Verification
REQ-025 Data write: d_valid, addr 0x10, wstrb 0xF, wdata 0xDEADBEEF -> ram_en=1, ram_wen=0xF, ram_addr=4 in cycle N; d_ready=1 in N+1.
REQ-026 Simultaneous reads after reset, d_addr 0x20 and i_addr 0x100 -> data granted first, acknowledged in N+1; instr granted N+2, i_ready N+3 with RAM word 0x40.
REQ-027 Both requesters valid continuously for 8 accesses -> grants strictly alternate D,I,D,I; 4 each; no ready overlap.
REQ-028 Instr read at 0x4000 with WORDS=4096 -> ram_en=0; i_ready=1 next cycle with i_rdata=0.
REQ-029 resetn pulsed low in WAIT -> d_ready stays 0; state IDLE; next tie goes to data.
